// File: rtl/game_sprite_display.sv
// game_sprite_display: per-pixel sprite hit test and bitmap lookup, 2-cycle pipeline to the pixel mixer.
// Optional feature macro GAME_SPRITE_MIRROR_EN adds the sprite_mirror input for horizontal flipping.
module game_sprite_display #(
   parameter int SPRITE_WIDTH  = 8,
   parameter int SPRITE_HEIGHT = 8,
   parameter int screen_width  = 640,
   parameter int screen_height = 480,
   parameter int w_x           = $clog2(screen_width),
   parameter int w_y           = $clog2(screen_height),
   parameter int w_rgb         = 3,
   parameter logic [w_rgb-1:0] TRANSPARENT = '0,
   parameter logic [SPRITE_WIDTH*SPRITE_HEIGHT*w_rgb-1:0] SPRITE_BITMAP =
      {(SPRITE_WIDTH*SPRITE_HEIGHT){3'b100}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             sprite_enable,
`ifdef GAME_SPRITE_MIRROR_EN
   input  logic             sprite_mirror,
`endif
   input  logic [w_x-1:0]   sprite_x,
   input  logic [w_y-1:0]   sprite_y,
   input  logic             pixel_valid,
   input  logic [w_x-1:0]   pixel_x,
   input  logic [w_y-1:0]   pixel_y,
   output logic             rgb_valid,
   output logic             rgb_en,
   output logic [w_rgb-1:0] rgb,
   output logic             sprite_drawn
);
   localparam int wc = $clog2(SPRITE_WIDTH);
   localparam int wr = $clog2(SPRITE_HEIGHT);
   localparam logic [w_x:0] span_x = (w_x+1)'(SPRITE_WIDTH);
   localparam logic [w_y:0] span_y = (w_y+1)'(SPRITE_HEIGHT);

   logic [w_x-1:0]   shadow_x;
   logic [w_y-1:0]   shadow_y;
   logic             shadow_en;
`ifdef GAME_SPRITE_MIRROR_EN
   logic             shadow_mirror;
`endif
   logic [w_x-1:0]   dx;
   logic [w_y-1:0]   dy;
   logic             hit_next;
   logic [wc-1:0]    col_next;
   logic             v1;
   logic             hit1;
   logic [wc-1:0]    col1;
   logic [wr-1:0]    row1;
   logic [w_rgb-1:0] pix;
   logic             en_next;

   // Shadow copy of the sprite state, updated only at frame boundaries so a frame is never torn
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_x  <= '0;
         shadow_y  <= '0;
         shadow_en <= 1'b0;
`ifdef GAME_SPRITE_MIRROR_EN
         shadow_mirror <= 1'b0;
`endif
      end else if (frame_start) begin
         shadow_x  <= sprite_x;
         shadow_y  <= sprite_y;
         shadow_en <= sprite_enable;
`ifdef GAME_SPRITE_MIRROR_EN
         shadow_mirror <= sprite_mirror;
`endif
      end
   end

   // Hit test with one extra bit on the far edges so a sprite at the screen border cannot wrap
   always_comb begin
      dx       = pixel_x - shadow_x;
      dy       = pixel_y - shadow_y;
      hit_next = shadow_en & pixel_valid
               & (pixel_x >= shadow_x) & ({1'b0, pixel_x} < {1'b0, shadow_x} + span_x)
               & (pixel_y >= shadow_y) & ({1'b0, pixel_y} < {1'b0, shadow_y} + span_y);
`ifdef GAME_SPRITE_MIRROR_EN
      col_next = shadow_mirror ? wc'(SPRITE_WIDTH-1) - dx[wc-1:0] : dx[wc-1:0];
`else
      col_next = dx[wc-1:0];
`endif
   end

   // Stage 1: register hit flag and bitmap coordinates
   always_ff @(posedge clk) begin
      if (rst) begin
         v1   <= 1'b0;
         hit1 <= 1'b0;
         col1 <= '0;
         row1 <= '0;
      end else begin
         v1   <= pixel_valid;
         hit1 <= hit_next;
         col1 <= col_next;
         row1 <= dy[wr-1:0];
      end
   end

   // Bitmap lookup; power-of-2 width lets {row,col} form the pixel index directly
   always_comb begin
      pix     = SPRITE_BITMAP[{row1, col1}*w_rgb +: w_rgb];
      en_next = hit1 & (pix != TRANSPARENT);
   end

   // Stage 2: registered colour output, forced to 0 when the sprite does not cover the pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_valid <= 1'b0;
         rgb_en    <= 1'b0;
         rgb       <= '0;
      end else begin
         rgb_valid <= v1;
         rgb_en    <= en_next;
         rgb       <= en_next ? pix : '0;
      end
   end

   // Sticky per-frame flag; frame_start clear takes priority over a coincident sprite pixel
   always_ff @(posedge clk) begin
      if (rst || frame_start) sprite_drawn <= 1'b0;
      else if (rgb_en) sprite_drawn <= 1'b1;
   end
endmodule
